// File: rtl/rv_isa_pkg.sv
// rtl/rv_isa_pkg.sv - RV32I optype indices, opcodes, loader FSM states and instruction packer
package rv_isa_pkg;

  // Bit positions inside the one-hot optype vector, shared with the decoder.
  localparam int OPT_W       = 10;
  localparam int OPT_R       = 0;
  localparam int OPT_I_LOAD  = 1;
  localparam int OPT_I_ARITH = 2;
  localparam int OPT_I_ECALL = 3;
  localparam int OPT_I_JALR  = 4;
  localparam int OPT_S       = 5;
  localparam int OPT_B       = 6;
  localparam int OPT_U_AUIPC = 7;
  localparam int OPT_U_LUI   = 8;
  localparam int OPT_J_JAL   = 9;

  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_I_ARITH = 7'b0010011;
  localparam logic [6:0] OP_I_ECALL = 7'b1110011;
  localparam logic [6:0] OP_I_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S       = 7'b0100011;
  localparam logic [6:0] OP_B       = 7'b1100011;
  localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_U_LUI   = 7'b0110111;
  localparam logic [6:0] OP_J_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Packs request fields into a 32-bit word; caller guarantees optype is one-hot.
  function automatic logic [31:0] encode_insn(
    input logic [OPT_W-1:0] optype,
    input logic [4:0]       rd,
    input logic [4:0]       rs1,
    input logic [4:0]       rs2,
    input logic [2:0]       funct3,
    input logic [6:0]       funct7,
    input logic [31:0]      imm
  );
    logic [31:0] word;
    word = 32'h0;
    case (1'b1)
      optype[OPT_R]:       word = {funct7, rs2, rs1, funct3, rd, OP_R};
      optype[OPT_I_LOAD]:  word = {imm[11:0], rs1, funct3, rd, OP_I_LOAD};
      optype[OPT_I_ARITH]: begin
        // Shift-immediate forms carry funct7 in the top bits and a 5-bit shamt.
        if ((funct3 == 3'b001) || (funct3 == 3'b101))
          word = {funct7, imm[4:0], rs1, funct3, rd, OP_I_ARITH};
        else
          word = {imm[11:0], rs1, funct3, rd, OP_I_ARITH};
      end
      optype[OPT_I_ECALL]: word = {imm[11:0], rs1, funct3, rd, OP_I_ECALL};
      optype[OPT_I_JALR]:  word = {imm[11:0], rs1, funct3, rd, OP_I_JALR};
      optype[OPT_S]:       word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
      optype[OPT_B]:       word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
      optype[OPT_U_AUIPC]: word = {imm[31:12], rd, OP_U_AUIPC};
      optype[OPT_U_LUI]:   word = {imm[31:12], rd, OP_U_LUI};
      optype[OPT_J_JAL]:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J_JAL};
      default:             word = 32'h0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/insn_encoder_loader_if.sv
// rtl/insn_encoder_loader_if.sv - request handshake and memory write port bundle
interface insn_encoder_loader_if #(
  parameter int ADDR_W = 32
) ();
  import rv_isa_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [OPT_W-1:0] req_optype;
  logic [4:0]       req_rd;
  logic [4:0]       req_rs1;
  logic [4:0]       req_rs2;
  logic [2:0]       req_funct3;
  logic [6:0]       req_funct7;
  logic [31:0]      req_imm;
  logic             req_last;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  // Master issues requests and acts as the memory; slave is the loader.
  modport master (
    output req_valid, req_optype, req_rd, req_rs1, req_rs2, req_funct3,
           req_funct7, req_imm, req_last, mem_ready,
    input  req_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_optype, req_rd, req_rs1, req_rs2, req_funct3,
           req_funct7, req_imm, req_last, mem_ready,
    output req_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/insn_fifo.sv
// rtl/insn_fifo.sv - synchronous FIFO with registered storage and head-of-queue output
module insn_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; a push is refused when full even if a pop happens this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/insn_encoder_loader.sv
// rtl/insn_encoder_loader.sv - packs RV32I field requests into words and streams them to instruction memory
module insn_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0100_0000)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  insn_encoder_loader_if.slave        bus,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [15:0]                 count
);

  state_t            state;
  state_t            state_next;
  logic              req_ready_c;
  logic              accept;
  logic              legal;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       fifo_head;
  logic [31:0]       insn_word;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       count_q;
  logic              err_q;

  assign legal     = $onehot(bus.req_optype);
  assign accept    = bus.req_valid && req_ready_c;
  assign push      = accept && legal;
  assign pop       = !fifo_empty && bus.mem_ready;
  assign insn_word = encode_insn(bus.req_optype, bus.req_rd, bus.req_rs1, bus.req_rs2,
                                 bus.req_funct3, bus.req_funct7, bus.req_imm);

  insn_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (insn_word),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Session state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and request-side handshake; requests are only taken in RUN.
  always_comb begin
    state_next  = state;
    req_ready_c = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN: begin
        req_ready_c = !fifo_full;
        if (bus.req_valid && !fifo_full && bus.req_last) state_next = ST_DRAIN;
      end
      // A write retires in the same cycle it pops, so empty means nothing is outstanding.
      ST_DRAIN: if (fifo_empty) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Write address, word counter and sticky illegal-optype flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= BASE_ADDR;
      count_q <= 16'd0;
      err_q   <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      addr_q  <= BASE_ADDR;
      count_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      if (pop) begin
        addr_q  <= addr_q + ADDR_W'(4);
        count_q <= count_q + 16'd1;
      end
      if (accept && !legal) err_q <= 1'b1;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.mem_we    = !fifo_empty;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = fifo_empty ? 32'h0 : fifo_head;
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign err           = err_q;
  assign count         = count_q;

endmodule

// File: tb/tb_insn_encoder_loader.sv
// tb/tb_insn_encoder_loader.sv - scoreboard bench for the instruction encoder/loader
module tb_insn_encoder_loader;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int RDY_ON   = 0;
  localparam int RDY_RAND = 1;
  localparam int RDY_OFF  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] count;

  int          checks = 0;
  int          failures = 0;
  int          ready_mode = RDY_ON;
  int          acc_cnt = 0;
  int          exp_count = 0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_addr = BASE;
  logic [63:0] exp_q[$];

  logic        hold;
  logic [31:0] held_addr;
  logic [31:0] held_data;

  insn_encoder_loader_if #(.ADDR_W(32)) bus ();

  insn_encoder_loader #(
    .DEPTH     (4),
    .ADDR_W    (32),
    .BASE_ADDR (32'h0100_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] oh(input int k);
    return 10'(1 << k);
  endfunction

  // Reference packer built from the field layout tables with shifts and masks.
  function automatic logic [31:0] model(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] opc [10];
    logic [31:0] u_rd, u_rs1, u_rs2, u_f3, u_f7, common;
    opc = '{32'h33, 32'h03, 32'h13, 32'h73, 32'h67, 32'h23, 32'h63, 32'h17, 32'h37, 32'h6F};
    u_rd = 32'(rd); u_rs1 = 32'(rs1); u_rs2 = 32'(rs2); u_f3 = 32'(f3); u_f7 = 32'(f7);
    common = (u_rs1 << 15) | (u_f3 << 12) | opc[k];
    case (k)
      0: return (u_f7 << 25) | (u_rs2 << 20) | common | (u_rd << 7);
      2: if (f3 == 3'd1 || f3 == 3'd5)
           return (u_f7 << 25) | ((imm & 32'h1f) << 20) | common | (u_rd << 7);
         else
           return ((imm & 32'hfff) << 20) | common | (u_rd << 7);
      1, 3, 4: return ((imm & 32'hfff) << 20) | common | (u_rd << 7);
      5: return (((imm >> 5) & 32'h7f) << 25) | (u_rs2 << 20) | common | ((imm & 32'h1f) << 7);
      6: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (u_rs2 << 20)
                | common | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 32'h1) << 7);
      7, 8: return (imm & 32'hffff_f000) | (u_rd << 7) | opc[k];
      default: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
                      | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hff) << 12)
                      | (u_rd << 7) | opc[k];
    endcase
  endfunction

  task automatic set_ready(input int m);
    ready_mode = m;
    if (m == RDY_ON)  bus.mem_ready = 1'b1;
    if (m == RDY_OFF) bus.mem_ready = 1'b0;
  endtask

  task automatic start_session();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr  = BASE;
    exp_count = 0;
    exp_err   = 1'b0;
  endtask

  // Presents one request, waits for the handshake, then records the expected write.
  task automatic send(input logic [9:0] opt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic last, input logic [31:0] exp_word);
    int waited = 0;
    bus.req_valid = 1'b1; bus.req_optype = opt; bus.req_rd = rd; bus.req_rs1 = rs1;
    bus.req_rs2 = rs2; bus.req_funct3 = f3; bus.req_funct7 = f7; bus.req_imm = imm;
    bus.req_last = last;
    do begin @(negedge clk); waited++; end while (!bus.req_ready && waited < 200);
    if (!bus.req_ready) begin
      check("req_accept_timeout", 64'(bus.req_ready), 64'd1);
    end else begin
      @(posedge clk);
      acc_cnt++;
      if ($onehot(opt)) begin
        exp_q.push_back({exp_addr, exp_word});
        exp_addr = exp_addr + 32'd4;
        exp_count++;
      end else begin
        exp_err = 1'b1;
      end
    end
    #1;
    bus.req_valid = 1'b0;
    bus.req_last  = 1'b0;
  endtask

  task automatic send_random(input logic last, input bit allow_bad);
    int k;
    logic [9:0] opt;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm;
    k = $urandom_range(0, 9);
    opt = oh(k);
    if (allow_bad && $urandom_range(0, 7) == 0) begin
      if ($urandom_range(0, 1) == 0) opt = 10'b0;
      else opt = oh(k) | oh((k + 1 + $urandom_range(0, 8)) % 10);
    end
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    f3 = 3'($urandom); f7 = 7'($urandom); imm = $urandom;
    send(opt, rd, rs1, rs2, f3, f7, imm, last, model(k, rd, rs1, rs2, f3, f7, imm));
  endtask

  task automatic end_session();
    int waited = 0;
    do begin @(negedge clk); waited++; end while (!done && waited < 300);
    check("done_pulse", 64'(done), 64'd1);
    check("count", 64'(count), 64'(exp_count));
    check("err", 64'(err), 64'(exp_err));
    @(negedge clk);
    check("done_single", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'(BASE));
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_count", 64'(count), 64'd0);
  endtask

  // Memory-side backpressure source.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_mode == RDY_RAND) bus.mem_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops the scoreboard on every accepted write and checks stall stability.
  initial begin
    logic [63:0] e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold && bus.mem_we) begin
          check("stall_addr_stable", 64'(bus.mem_addr), 64'(held_addr));
          check("stall_data_stable", 64'(bus.mem_wdata), 64'(held_data));
        end
        if (bus.mem_we && bus.mem_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 64'(bus.mem_we), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(bus.mem_addr), 64'(e[63:32]));
            check("wr_data", 64'(bus.mem_wdata), 64'(e[31:0]));
          end
        end
        hold      = bus.mem_we && !bus.mem_ready;
        held_addr = bus.mem_addr;
        held_data = bus.mem_wdata;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0;
    bus.req_valid = 1'b0; bus.req_optype = '0; bus.req_rd = '0; bus.req_rs1 = '0;
    bus.req_rs2 = '0; bus.req_funct3 = '0; bus.req_funct7 = '0; bus.req_imm = '0;
    bus.req_last = 1'b0;
    set_ready(RDY_ON);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // add x3, x1, x2
    start_session();
    send(oh(0), 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3);
    end_session();

    // addi x5, x0, -1 ; sw x2, 8(x1)
    start_session();
    send(oh(2), 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00293);
    send(oh(5), 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'h0020A423);
    end_session();

    // beq x0, x0, -4 ; jal x1, 2048 ; lui x10, 0x12345
    start_session();
    send(oh(6), 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'hFE000EE3);
    send(oh(9), 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h001000EF);
    send(oh(8), 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h12345537);
    end_session();

    // Six requests against a stalled memory: FIFO fills after four accepts.
    set_ready(RDY_OFF);
    start_session();
    acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_random(i == 5, 1'b0);
      end
      begin
        repeat (8) @(negedge clk);
        check("stall_accepts", 64'(acc_cnt), 64'd4);
        check("stall_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        set_ready(RDY_ON);
      end
    join
    end_session();

    // Illegal optype mid-session is consumed without a write.
    start_session();
    send(oh(2), 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00293);
    send(10'b00_0000_0011, 5'd7, 5'd7, 5'd7, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0);
    check("illegal_err_set", 64'(err), 64'd1);
    check("illegal_count_held", 64'(count), 64'd1);
    send(oh(8), 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h12345537);
    end_session();

    // Randomized sessions with random backpressure and occasional illegal optypes.
    for (int s = 0; s < 8; s++) begin
      int n;
      n = $urandom_range(3, 10);
      set_ready(RDY_RAND);
      start_session();
      for (int i = 0; i < n; i++) send_random(i == n - 1, 1'b1);
      end_session();
    end

    // Reset with words still queued aborts the session.
    set_ready(RDY_OFF);
    start_session();
    send(10'b0, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) send_random(1'b0, 1'b0);
    check("pre_reset_err", 64'(err), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    set_ready(RDY_ON);
    @(negedge clk);
    check_reset_outputs();
    bus.req_valid = 1'b1; bus.req_optype = oh(0);
    repeat (5) begin
      @(negedge clk);
      check("post_reset_no_ready", 64'(bus.req_ready), 64'd0);
      check("post_reset_no_we", 64'(bus.mem_we), 64'd0);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;

    start_session();
    send_random(1'b0, 1'b0);
    send_random(1'b1, 1'b0);
    end_session();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/insn_encoder_loader.md
Name: insn_encoder_loader

Overview:
- Inverse of the pipeline's instruction decoder: accepts field-level RV32I instruction requests (one-hot optype, rd/rs1/rs2/funct3/funct7/imm) over a valid/ready handshake.
- Packs each request into a 32-bit instruction word and buffers it in a small FIFO.
- Writes the words sequentially into instruction memory through a write port with backpressure.
- Used by the testbench/boot path to load programs without a hex file.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 32, memory address width
BASE_ADDR, 32'h0100_0000, first write address after start

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
start  input  1  begin a load session (honoured only in IDLE)
req_valid  input  1  request valid
req_ready  output  1  request accepted when valid&&ready
req_optype  input  10  one-hot: 0 R, 1 I_loads, 2 I_arith, 3 I_ecall, 4 I_jalr, 5 S, 6 B, 7 U_auipc, 8 U_lui, 9 J_jal
req_rd / req_rs1 / req_rs2  input  5 each  register fields
req_funct3  input  3  funct3
req_funct7  input  7  funct7 (R type and I_arith shifts)
req_imm  input  32  immediate, byte offset, sign-extended value
req_last  input  1  marks final request of session
mem_we  output  1  write request
mem_addr  output  ADDR_W  write address
mem_wdata  output  32  encoded instruction
mem_ready  input  1  memory accepts write when mem_we&&mem_ready
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at session end
err  output  1  sticky illegal-optype flag
count  output  16  words written this session

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, FIFO empty, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, req_ready=0, busy=0, done=0, err=0, count=0. Reset mid-session aborts immediately; pending words are lost.
- FSM:
  - IDLE: start -> RUN; mem_addr<=BASE_ADDR, count<=0, err<=0.
  - RUN: req_ready = !fifo_full. Accepting a request with req_last=1 -> DRAIN.
  - DRAIN: req_ready=0. Move to DONE when the FIFO is empty and no write is outstanding.
  - DONE: done=1 for one cycle -> IDLE.
  - start outside IDLE is ignored. req_ready=0 in IDLE, DRAIN and DONE.
- Encoding (combinational, written into the FIFO on accept):
  - Opcodes: R 0110011; I_loads 0000011; I_arith 0010011; I_ecall 1110011; I_jalr 1100111; S 0100011; B 1100011; U_auipc 0010111; U_lui 0110111; J_jal 1101111.
  - R: {funct7,rs2,rs1,f3,rd,op}.
  - I: {imm[11:0],rs1,f3,rd,op}. I_arith with f3=001/101 uses {funct7,imm[4:0]} in [31:20].
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; imm[0] ignored.
  - U: {imm[31:12],rd,op}.
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}; imm[0] ignored.
  - Any field not used by the format is ignored.
- Illegal optype (not exactly one bit set): the request is still consumed (handshake completes), nothing is enqueued, err<=1 until the next start. If req_last=1 it still ends the session.
- Latency: a request accepted at cycle N gives earliest mem_we=1 at N+1. The FIFO head is registered; there is no bypass.
- Write port: mem_we = FIFO non-empty. mem_addr/mem_wdata hold stable while mem_we && !mem_ready. On mem_we && mem_ready: pop, mem_addr += 4 (wraps modulo 2^ADDR_W), count += 1 (wraps at 16 bits).
- Simultaneous push/pop in one cycle is allowed, except push is blocked when full even if a pop occurs that cycle.
- Words are written in exact acceptance order.

Decomposition:
- Package rv_isa_pkg: optype index localparams (shared with the decoder), 7-bit opcode constants, FSM state enum.
- Sub-module insn_fifo: synchronous FIFO with DEPTH and WIDTH=32 parameters, push/pop/full/empty/head.

Test Plan:
- start; R add rd=3 rs1=1 rs2=2 f3=0 f7=0, last=1 -> mem_wdata 0x002081B3 at 0x01000000, done pulse, count=1, err=0.
- I_arith addi rd=5 rs1=0 imm=-1, then S sw rs2=2 rs1=1 f3=010 imm=8 -> 0xFFF00293 at 0x01000000, 0x0020A423 at 0x01000004.
- B beq rs1=0 rs2=0 imm=-4; J_jal rd=1 imm=2048; U_lui rd=10 imm=0x12345000 -> 0xFE000EE3, 0x001000EF, 0x12345537 at consecutive addresses.
- 6 requests, mem_ready=0 for 8 cycles, DEPTH=4 -> req_ready drops after 4 accepts; mem_addr/wdata stable while stalled; all 6 written in order to BASE..BASE+20; count=6; single done pulse.
- optype=10'b0000000011 mid-session -> err=1, no write, address and count unchanged; next valid request goes to the next address.
- rst_n=0 for 1 cycle with 3 words queued -> all outputs at reset values next cycle; no further mem_we; start needed to resume.
